// File: rtl/pid_core.sv
// Balance-controller PID core: P/I/D terms from the saturated pitch error,
// saturated 12-bit registered effort, plus a saturating soft-start timer.
module pid_core #(
    parameter logic [4:0]  P_COEFF = 5'd9,
    parameter logic [5:0]  D_COEFF = 6'd22,
    parameter logic [26:0] SS_INC  = 27'd1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic signed [9:0]  err_sat,
    input  logic               pwr_up,
    input  logic               rider_off,
    output logic signed [11:0] PID_cntrl,
    output logic               pid_vld,
    output logic        [7:0]  ss_tmr_hi
);

    localparam logic [26:0] SS_MAX = 27'h7FF_FFFF;

    logic [17:0] r_integ;
    logic [9:0]  r_prev1;
    logic [9:0]  r_prev2;
    logic [11:0] r_pid;
    logic        r_pidVld;
    logic [26:0] r_ssTmr;

    logic [14:0] w_pTerm;
    logic [17:0] w_integCand;
    logic        w_integOvf;
    logic [17:0] w_integNext;
    logic [15:0] w_iTerm;
    logic [10:0] w_dDiff;
    logic [6:0]  w_dSat;
    logic [12:0] w_dTerm;
    logic [15:0] w_sum;
    logic [11:0] w_sumSat;
    logic [27:0] w_ssSum;
    logic [26:0] w_ssNext;

    // Products are taken modulo the result width; operands are pre-extended so
    // the low bits are the correct two's-complement product.
    assign w_pTerm = {{5{err_sat[9]}}, err_sat} * {10'd0, P_COEFF};

    assign w_integCand = r_integ + {{8{err_sat[9]}}, err_sat};
    assign w_integOvf  = (r_integ[17] == err_sat[9]) && (w_integCand[17] != r_integ[17]);

    always_comb begin
        w_integNext = r_integ;
        if (!pwr_up || rider_off) begin
            w_integNext = 18'd0;
        end else if (vld && !w_integOvf) begin
            w_integNext = w_integCand;
        end
    end

    // The I term uses the value the integrator is about to take, so a clear
    // in the same cycle as a sample already removes its contribution.
    assign w_iTerm = {{4{w_integNext[17]}}, w_integNext[17:6]};

    assign w_dDiff = {err_sat[9], err_sat} - {r_prev2[9], r_prev2};

    always_comb begin
        w_dSat = w_dDiff[6:0];
        if (!w_dDiff[10] && (w_dDiff[9:6] != 4'h0)) begin
            w_dSat = 7'h3F;
        end else if (w_dDiff[10] && (w_dDiff[9:6] != 4'hF)) begin
            w_dSat = 7'h40;
        end
    end

    assign w_dTerm = {{6{w_dSat[6]}}, w_dSat} * {7'd0, D_COEFF};

    assign w_sum = {w_pTerm[14], w_pTerm} + w_iTerm + {{3{w_dTerm[12]}}, w_dTerm};

    always_comb begin
        w_sumSat = w_sum[11:0];
        if (!w_sum[15] && (w_sum[14:11] != 4'h0)) begin
            w_sumSat = 12'h7FF;
        end else if (w_sum[15] && (w_sum[14:11] != 4'hF)) begin
            w_sumSat = 12'h800;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_integ <= 18'd0;
        end else begin
            r_integ <= w_integNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev1 <= 10'd0;
            r_prev2 <= 10'd0;
        end else if (vld) begin
            r_prev2 <= r_prev1;
            r_prev1 <= err_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pid    <= 12'd0;
            r_pidVld <= 1'b0;
        end else begin
            r_pidVld <= vld;
            if (vld) begin
                r_pid <= w_sumSat;
            end
        end
    end

    // All-ones is the ceiling, so a carry out of the add means saturation.
    assign w_ssSum  = {1'b0, r_ssTmr} + {1'b0, SS_INC};
    assign w_ssNext = w_ssSum[27] ? SS_MAX : w_ssSum[26:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ssTmr <= 27'd0;
        end else if (!pwr_up) begin
            r_ssTmr <= 27'd0;
        end else begin
            r_ssTmr <= w_ssNext;
        end
    end

    assign PID_cntrl = r_pid;
    assign pid_vld   = r_pidVld;
    assign ss_tmr_hi = r_ssTmr[26:19];

endmodule

// File: tb/tb_pid_core.sv
// Directed bench for pid_core: a table of hand-computed samples plus
// sequences for reset, integrator overflow and soft-start behaviour.
module tb_pid_core;

    logic               clk;
    logic               rst_n;
    logic               vld;
    logic signed [9:0]  err_sat;
    logic               pwr_up;
    logic               rider_off;
    logic signed [11:0] PID_cntrl;
    logic               pid_vld;
    logic        [7:0]  ss_tmr_hi;

    int numCompared = 0;
    int numFailed   = 0;

    typedef struct {
        logic               vld;
        logic signed [9:0]  err;
        logic               pwrUp;
        logic               riderOff;
        logic signed [11:0] expPid;
        logic               expVld;
    } vec_t;

    vec_t vecs [12];

    pid_core #(
        .P_COEFF(5'd9),
        .D_COEFF(6'd22),
        .SS_INC (27'h80000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld      (vld),
        .err_sat  (err_sat),
        .pwr_up   (pwr_up),
        .rider_off(rider_off),
        .PID_cntrl(PID_cntrl),
        .pid_vld  (pid_vld),
        .ss_tmr_hi(ss_tmr_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input int expected);
        numCompared++;
        if (actual !== expected) begin
            numFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs at the falling edge; returns 1 ns after the
    // rising edge that consumed them, with vld dropped again.
    task automatic applyStimulus(input logic v, input logic signed [9:0] e,
                                 input logic p, input logic r);
        @(negedge clk);
        vld       = v;
        err_sat   = e;
        pwr_up    = p;
        rider_off = r;
        @(posedge clk);
        #1;
        vld = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_pid", $signed(PID_cntrl), 0);
        checkOutput("async_rst_vld", 32'(pid_vld), 0);
        checkOutput("async_rst_ss", 32'(ss_tmr_hi), 0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, -10'sd10,  1'b1, 1'b0, -12'sd311,  1'b1};
        vecs[1]  = '{1'b1, -10'sd10,  1'b1, 1'b0, -12'sd311,  1'b1};
        vecs[2]  = '{1'b1, -10'sd10,  1'b1, 1'b0, -12'sd91,   1'b1};
        vecs[3]  = '{1'b0,  10'sd0,   1'b1, 1'b0, -12'sd91,   1'b0};
        vecs[4]  = '{1'b1, -10'sd10,  1'b1, 1'b1, -12'sd90,   1'b1};
        vecs[5]  = '{1'b1,  10'sd20,  1'b1, 1'b0,  12'sd840,  1'b1};
        vecs[6]  = '{1'b1, -10'sd200, 1'b1, 1'b0, -12'sd2048, 1'b1};
        vecs[7]  = '{1'b1,  10'sd0,   1'b1, 1'b0, -12'sd443,  1'b1};
        vecs[8]  = '{1'b1,  10'sd5,   1'b1, 1'b0,  12'sd1428, 1'b1};
        vecs[9]  = '{1'b1, -10'sd512, 1'b1, 1'b0, -12'sd2048, 1'b1};
        vecs[10] = '{1'b1,  10'sd64,  1'b0, 1'b0,  12'sd1874, 1'b1};
        vecs[11] = '{1'b1,  10'sd1,   1'b1, 1'b0,  12'sd1395, 1'b1};

        rst_n     = 1'b0;
        vld       = 1'b0;
        err_sat   = '0;
        pwr_up    = 1'b0;
        rider_off = 1'b0;
        #3;
        checkOutput("reset_pid", $signed(PID_cntrl), 0);
        checkOutput("reset_vld", 32'(pid_vld), 0);
        checkOutput("reset_ss", 32'(ss_tmr_hi), 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 10'sd100, 1'b1, 1'b0);
        checkOutput("first_sample_pid", $signed(PID_cntrl), 2047);
        checkOutput("first_sample_vld", 32'(pid_vld), 1);
        applyStimulus(1'b0, 10'sd0, 1'b1, 1'b0);
        checkOutput("first_sample_hold", $signed(PID_cntrl), 2047);
        checkOutput("first_sample_vld_drop", 32'(pid_vld), 0);

        pulseReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].vld, vecs[i].err, vecs[i].pwrUp, vecs[i].riderOff);
            checkOutput($sformatf("vec%0d_pid", i), $signed(PID_cntrl), int'(vecs[i].expPid));
            checkOutput($sformatf("vec%0d_vld", i), 32'(pid_vld), int'(vecs[i].expVld));
            if (i == 2) checkOutput("integ_after_three", $signed(dut.r_integ), -30);
            if (i == 4) checkOutput("integ_rider_off", $signed(dut.r_integ), 0);
        end

        pulseReset();
        applyStimulus(1'b1, 10'sd100, 1'b1, 1'b0);
        checkOutput("post_reset_pid", $signed(PID_cntrl), 2047);
        checkOutput("post_reset_integ", $signed(dut.r_integ), 100);

        pulseReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 10'sd511, 1'b1, 1'b0);
        end
        checkOutput("integ_256", $signed(dut.r_integ), 130816);
        applyStimulus(1'b1, 10'sd511, 1'b1, 1'b0);
        checkOutput("integ_257_hold", $signed(dut.r_integ), 130816);
        checkOutput("pid_257_sat", $signed(PID_cntrl), 2047);
        applyStimulus(1'b1, 10'sd0, 1'b1, 1'b0);
        checkOutput("pid_after_ovf", $signed(PID_cntrl), 636);

        applyStimulus(1'b0, 10'sd0, 1'b0, 1'b0);
        checkOutput("ss_cleared", 32'(ss_tmr_hi), 0);
        @(negedge clk);
        pwr_up = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            @(posedge clk);
            #1;
            if (k == 1)   checkOutput("ss_k1", 32'(ss_tmr_hi), 1);
            if (k == 128) checkOutput("ss_k128", 32'(ss_tmr_hi), 128);
            if (k == 254) checkOutput("ss_k254", 32'(ss_tmr_hi), 254);
            if (k == 255) checkOutput("ss_k255", 32'(ss_tmr_hi), 255);
            if (k == 260) checkOutput("ss_k260_hold", 32'(ss_tmr_hi), 255);
        end
        applyStimulus(1'b0, 10'sd0, 1'b0, 1'b0);
        checkOutput("ss_pwr_off", 32'(ss_tmr_hi), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numFailed);
        $finish;
    end

endmodule
